// File: rtl/fetch_unit.sv
// fetch_unit: pipeline front end.
// Owns the program counter and reads instruction memory combinationally.
// Drives the fetch->decode registers: O_PC, O_IR and the O_FetchStall bubble flag.
// Holds on a decode dependency stall. On a decode branch stall it bubbles until the
// redirect pulse arrives, then loads the PC from the redirect target.
// Ports:
//   I_CLOCK, I_RESET_N (async, active-low), I_LOCK (global run enable) -> O_LOCK
//   O_IMemAddr / I_IMemData : instruction memory read (same-cycle)
//   I_DepStallSignal, I_BranchStallSignal : decode back-pressure
//   I_BranchPCSignal, I_BranchPC : redirect pulse and target
//   O_PC, O_IR, O_FetchStall : fetch->decode payload
// Optional feature macro FETCH_PERF_CNT_EN adds two counters:
//   O_StallCycles and O_BranchCount, both saturating at 32'hFFFF_FFFF.
module fetch_unit #(
  parameter int unsigned          PC_WIDTH = 32,
  parameter int unsigned          IR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(32'h0000_0000)
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  output logic [PC_WIDTH-1:0] O_IMemAddr,
  input  logic [IR_WIDTH-1:0] I_IMemData,
  input  logic                I_DepStallSignal,
  input  logic                I_BranchStallSignal,
  input  logic                I_BranchPCSignal,
  input  logic [PC_WIDTH-1:0] I_BranchPC,
  output logic                O_LOCK,
  output logic [PC_WIDTH-1:0] O_PC,
  output logic [IR_WIDTH-1:0] O_IR,
  output logic                O_FetchStall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         O_StallCycles,
  output logic [31:0]         O_BranchCount
`endif
);

  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   opc_q, opc_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic                  stall_q, stall_d;
  logic                  lock_q;

  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  do_fetch;
  logic                  enter_wait;
  logic                  unused_bpc_lo;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  assign redirect_pc   = {I_BranchPC[PC_WIDTH-1:2], 2'b00};
  assign unused_bpc_lo = ^I_BranchPC[1:0];
  assign pc_inc        = pc_q + PC_WIDTH'(4);

  // RUN-state decisions in priority order: redirect > dep stall > branch stall > fetch.
  assign do_fetch   = (state_q == ST_RUN) && !I_BranchPCSignal && !I_DepStallSignal
                      && !I_BranchStallSignal;
  assign enter_wait = (state_q == ST_RUN) && !I_BranchPCSignal && !I_DepStallSignal
                      && I_BranchStallSignal;

  // State and output registers.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      ir_q    <= '0;
      stall_q <= 1'b1;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      ir_q    <= ir_d;
      stall_q <= stall_d;
      lock_q  <= I_LOCK;
    end
  end

  // Next-state logic; everything holds while I_LOCK is low.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    ir_d    = ir_q;
    stall_d = stall_q;
    if (I_LOCK) begin
      case (state_q)
        ST_RUN: begin
          if (I_BranchPCSignal) begin
            pc_d    = redirect_pc;
            stall_d = 1'b1;
          end else if (do_fetch) begin
            ir_d    = I_IMemData;
            opc_d   = pc_inc;
            pc_d    = pc_inc;
            stall_d = 1'b0;
          end else if (enter_wait) begin
            stall_d = 1'b1;
            state_d = ST_BR_WAIT;
          end
          // Dependency stall: all fetch state holds so decode re-examines it.
        end
        ST_BR_WAIT: begin
          // Bubble every cycle, including the redirect cycle itself.
          stall_d = 1'b1;
          if (I_BranchPCSignal) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign O_IMemAddr   = pc_q;
  assign O_PC         = opc_q;
  assign O_IR         = ir_q;
  assign O_FetchStall = stall_q;
  assign O_LOCK       = lock_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic                 stall_evt;
  logic                 br_evt;

  // Any locked edge that does not fetch a new instruction produces a bubble or a hold.
  assign stall_evt = I_LOCK && !do_fetch;
  assign br_evt    = I_LOCK && enter_wait;

  // Saturating performance counters.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      stall_cnt_q <= '0;
      br_cnt_q    <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (br_evt && (br_cnt_q != '1))       br_cnt_q    <= br_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign O_StallCycles = stall_cnt_q;
  assign O_BranchCount = br_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of per-cycle inputs with hand-derived
// expected outputs, queued as expectations when driven and compared after the edge.
// A second instance with RESET_PC=0xFFFF_FFFC covers the PC wrap.
module tb_fetch_unit;

  logic        I_CLOCK;
  logic        I_RESET_N;
  logic        I_LOCK;
  logic [31:0] O_IMemAddr;
  logic [31:0] I_IMemData;
  logic        I_DepStallSignal;
  logic        I_BranchStallSignal;
  logic        I_BranchPCSignal;
  logic [31:0] I_BranchPC;
  logic        O_LOCK;
  logic [31:0] O_PC;
  logic [31:0] O_IR;
  logic        O_FetchStall;

  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_lock;
  logic [31:0] w_pc;
  logic [31:0] w_ir;
  logic        w_stall;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] O_StallCycles, O_BranchCount;
  logic [31:0] w_sc, w_bc;
`endif

  // Instruction memory: {16'hA000, addr[15:0]}.
  assign I_IMemData = {16'hA000, O_IMemAddr[15:0]};
  assign w_data     = {16'hA000, w_addr[15:0]};

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .O_IMemAddr(O_IMemAddr), .I_IMemData(I_IMemData),
    .I_DepStallSignal(I_DepStallSignal), .I_BranchStallSignal(I_BranchStallSignal),
    .I_BranchPCSignal(I_BranchPCSignal), .I_BranchPC(I_BranchPC),
    .O_LOCK(O_LOCK), .O_PC(O_PC), .O_IR(O_IR), .O_FetchStall(O_FetchStall)
`ifdef FETCH_PERF_CNT_EN
    , .O_StallCycles(O_StallCycles), .O_BranchCount(O_BranchCount)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
    .O_IMemAddr(w_addr), .I_IMemData(w_data),
    .I_DepStallSignal(I_DepStallSignal), .I_BranchStallSignal(I_BranchStallSignal),
    .I_BranchPCSignal(I_BranchPCSignal), .I_BranchPC(I_BranchPC),
    .O_LOCK(w_lock), .O_PC(w_pc), .O_IR(w_ir), .O_FetchStall(w_stall)
`ifdef FETCH_PERF_CNT_EN
    , .O_StallCycles(w_sc), .O_BranchCount(w_bc)
`endif
  );

  initial begin
    I_CLOCK = 1'b0;
    forever #5 I_CLOCK = ~I_CLOCK;
  end

  typedef struct {
    logic        lock, dep, brs, brv;
    logic [31:0] bpc;
    logic [31:0] addr, pc, ir;
    logic        stall, olock;
    logic        sc, bc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] addr, pc, ir;
    logic        stall, olock;
    logic [31:0] scnt, bcnt;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[27];
  logic [31:0] m_sc = 0;
  logic [31:0] m_bc = 0;

  function automatic vec_t mk(input logic lock, dep, brs, brv, input logic [31:0] bpc,
                              input logic [31:0] addr, pc, ir, input logic stall, olock,
                              input logic sc, bc);
    vec_t v;
    v.lock = lock; v.dep = dep; v.brs = brs; v.brv = brv; v.bpc = bpc;
    v.addr = addr; v.pc = pc; v.ir = ir; v.stall = stall; v.olock = olock;
    v.sc = sc; v.bc = bc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [step %0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input int idx, input vec_t t);
    exp_t e;
    @(negedge I_CLOCK);
    I_LOCK = t.lock; I_DepStallSignal = t.dep; I_BranchStallSignal = t.brs;
    I_BranchPCSignal = t.brv; I_BranchPC = t.bpc;
    if (t.lock && t.sc) m_sc = m_sc + 1;
    if (t.lock && t.bc) m_bc = m_bc + 1;
    e.idx = idx; e.addr = t.addr; e.pc = t.pc; e.ir = t.ir;
    e.stall = t.stall; e.olock = t.olock; e.scnt = m_sc; e.bcnt = m_bc;
    sb.push_back(e);
    @(posedge I_CLOCK);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard [step %0d]: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk("O_IMemAddr", e.idx, O_IMemAddr, e.addr);
      chk("O_PC", e.idx, O_PC, e.pc);
      chk("O_IR", e.idx, O_IR, e.ir);
      chk("O_FetchStall", e.idx, 32'(O_FetchStall), 32'(e.stall));
      chk("O_LOCK", e.idx, 32'(O_LOCK), 32'(e.olock));
`ifdef FETCH_PERF_CNT_EN
      chk("O_StallCycles", e.idx, O_StallCycles, e.scnt);
      chk("O_BranchCount", e.idx, O_BranchCount, e.bcnt);
`endif
    end
  endtask

  task automatic chk_reset(input int idx);
    chk("rst O_IMemAddr", idx, O_IMemAddr, 32'h0000_0100);
    chk("rst O_PC", idx, O_PC, 32'h0);
    chk("rst O_IR", idx, O_IR, 32'h0);
    chk("rst O_FetchStall", idx, 32'(O_FetchStall), 32'h1);
    chk("rst O_LOCK", idx, 32'(O_LOCK), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst O_StallCycles", idx, O_StallCycles, 32'h0);
    chk("rst O_BranchCount", idx, O_BranchCount, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              lk d  bs bv bpc            addr           pc             ir             st lk sc bc
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,       32'h104, 32'h104, 32'hA000_0100, 0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h0,       32'h108, 32'h108, 32'hA000_0104, 0, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,       32'h108, 32'h108, 32'hA000_0104, 0, 1, 1, 0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,       32'h108, 32'h108, 32'hA000_0104, 0, 1, 1, 0);
    vecs[4]  = mk(1, 0, 0, 0, 32'h0,       32'h10C, 32'h10C, 32'hA000_0108, 0, 1, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 32'h0,       32'h10C, 32'h10C, 32'hA000_0108, 1, 1, 1, 1);
    vecs[6]  = mk(1, 0, 0, 0, 32'h0,       32'h10C, 32'h10C, 32'hA000_0108, 1, 1, 1, 0);
    vecs[7]  = mk(1, 1, 1, 0, 32'h0,       32'h10C, 32'h10C, 32'hA000_0108, 1, 1, 1, 0);
    vecs[8]  = mk(1, 0, 0, 1, 32'h203,     32'h200, 32'h10C, 32'hA000_0108, 1, 1, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 32'h0,       32'h204, 32'h204, 32'hA000_0200, 0, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 32'h0,       32'h208, 32'h208, 32'hA000_0204, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,       32'h208, 32'h208, 32'hA000_0204, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 32'h400,     32'h208, 32'h208, 32'hA000_0204, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 32'h0,       32'h208, 32'h208, 32'hA000_0204, 0, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 32'h0,       32'h20C, 32'h20C, 32'hA000_0208, 0, 1, 0, 0);
    vecs[15] = mk(1, 0, 0, 1, 32'h3FF,     32'h3FC, 32'h20C, 32'hA000_0208, 1, 1, 1, 0);
    vecs[16] = mk(1, 0, 0, 0, 32'h0,       32'h400, 32'h400, 32'hA000_03FC, 0, 1, 0, 0);
    vecs[17] = mk(1, 1, 0, 1, 32'h501,     32'h500, 32'h400, 32'hA000_03FC, 1, 1, 1, 0);
    vecs[18] = mk(1, 1, 0, 0, 32'h0,       32'h500, 32'h400, 32'hA000_03FC, 1, 1, 1, 0);
    vecs[19] = mk(1, 0, 0, 0, 32'h0,       32'h504, 32'h504, 32'hA000_0500, 0, 1, 0, 0);
    vecs[20] = mk(1, 0, 1, 0, 32'h0,       32'h504, 32'h504, 32'hA000_0500, 1, 1, 1, 1);
    vecs[21] = mk(1, 0, 0, 1, 32'h600,     32'h600, 32'h504, 32'hA000_0500, 1, 1, 1, 0);
    vecs[22] = mk(1, 0, 0, 0, 32'h0,       32'h604, 32'h604, 32'hA000_0600, 0, 1, 0, 0);
    vecs[23] = mk(1, 0, 1, 0, 32'h0,       32'h604, 32'h604, 32'hA000_0600, 1, 1, 1, 1);
    vecs[24] = mk(1, 0, 0, 0, 32'h0,       32'h104, 32'h104, 32'hA000_0100, 0, 1, 0, 0);
    vecs[25] = mk(1, 0, 0, 1, 32'h700,     32'h700, 32'h104, 32'hA000_0100, 1, 1, 1, 0);
    vecs[26] = mk(1, 0, 0, 0, 32'h0,       32'h704, 32'h704, 32'hA000_0700, 0, 1, 0, 0);

    I_RESET_N = 1'b0; I_LOCK = 1'b0; I_DepStallSignal = 1'b0;
    I_BranchStallSignal = 1'b0; I_BranchPCSignal = 1'b0; I_BranchPC = 32'h0;
    #12;
    chk_reset(-1);
    chk("wrap rst O_IMemAddr", -1, w_addr, 32'hFFFF_FFFC);
    @(negedge I_CLOCK);
    I_RESET_N = 1'b1;

    // First fetch: wrap instance checked alongside the main one.
    apply(0, vecs[0]);
    chk("wrap O_PC", 0, w_pc, 32'h0);
    chk("wrap O_IMemAddr", 0, w_addr, 32'h0);
    chk("wrap O_IR", 0, w_ir, 32'hA000_FFFC);
    apply(1, vecs[1]);
    chk("wrap O_PC", 1, w_pc, 32'h4);
    chk("wrap O_IR", 1, w_ir, 32'hA000_0000);

    for (int i = 2; i < 24; i++) apply(i, vecs[i]);

    // Asynchronous reset while waiting in BR_WAIT: outputs change before the next edge.
    @(negedge I_CLOCK);
    I_LOCK = 1'b0; I_DepStallSignal = 1'b0; I_BranchStallSignal = 1'b0;
    I_BranchPCSignal = 1'b0; I_BranchPC = 32'h0;
    #2 I_RESET_N = 1'b0;
    m_sc = 0; m_bc = 0;
    #1;
    chk_reset(100);
    @(negedge I_CLOCK);
    I_RESET_N = 1'b1;

    // Restart at RESET_PC; the late redirect is a plain RUN redirect.
    for (int i = 24; i < 27; i++) apply(i, vecs[i]);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
